// File: rtl/vga_pkg.sv
// Shared types and constants for the 160x120 framebuffer scan-out path.
// The address helper keeps the row*160 product multiplier-free.
package vga_pkg;

   localparam int H_TOTAL = 800;
   localparam int V_TOTAL = 525;
   localparam int FB_W    = 160;
   localparam int FB_H    = 120;

   typedef logic [2:0]  colour_t;
   typedef logic [14:0] fb_addr_t;

   // row*160 + col as (row<<7) + (row<<5) + col
   function automatic fb_addr_t fb_addr(input logic [6:0] row, input logic [7:0] col);
      return (fb_addr_t'(row) << 7) + (fb_addr_t'(row) << 5) + fb_addr_t'(col);
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate tick, line/frame counters and raw sync/visible
// flags decoded from the counters, plus the one-clk frame_start strobe.
module vga_timing_gen #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       resetn,
   output logic       pix_tick,
   output logic [9:0] hc,
   output logic [9:0] vc,
   output logic       visible,
   output logic       hs_n,
   output logic       vs_n,
   output logic       frame_start
);

   localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS_C = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C = 10'(V_VIS);
   localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values and the update order inside the block is irrelevant.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pix_tick    <= 1'b0;
         hc          <= '0;
         vc          <= '0;
         frame_start <= 1'b0;
      end else begin
         pix_tick    <= ~pix_tick;
         frame_start <= pix_tick && (hc == '0) && (vc == '0);
         if (pix_tick) begin
            if (hc == H_LAST) begin
               hc <= '0;
               vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
            end else begin
               hc <= hc + 10'd1;
            end
         end
      end
   end

   assign visible = (hc < H_VIS_C) && (vc < V_VIS_C);
   assign hs_n    = !((hc >= HS_BEG) && (hc < HS_END));
   assign vs_n    = !((vc >= VS_BEG) && (vc < VS_END));

endmodule

// File: rtl/vga_scanout_reader.sv
// Framebuffer read side: issues 4x-upscaled reads to a 1-clk-latency RAM and
// drives the VGA DAC/sync pins through a two-stage pixel-rate pipeline.
module vga_scanout_reader
   import vga_pkg::*;
#(
   parameter int H_VIS       = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_VIS       = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SCALE_SHIFT = 2,
   parameter int COLOR_W     = 3,
   parameter int ADDR_W      = 15
) (
   input  logic               clk,
   input  logic               resetn,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [COLOR_W-1:0] rd_data,
   output logic [9:0]         VGA_R,
   output logic [9:0]         VGA_G,
   output logic [9:0]         VGA_B,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK,
   output logic               VGA_SYNC,
   output logic               VGA_CLK,
   output logic               frame_start
);

   logic       pix_tick;
   logic [9:0] hc;
   logic [9:0] vc;
   logic       visible;
   logic       hs_n;
   logic       vs_n;
   logic       s1_vis;
   logic       s1_hs;
   logic       s1_vs;
   logic [6:0] row;
   logic [7:0] col;
   colour_t    pix;

   vga_timing_gen #(
      .H_VIS (H_VIS),  .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_VIS (V_VIS),  .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk         (clk),
      .resetn      (resetn),
      .pix_tick    (pix_tick),
      .hc          (hc),
      .vc          (vc),
      .visible     (visible),
      .hs_n        (hs_n),
      .vs_n        (vs_n),
      .frame_start (frame_start)
   );

   // Only meaningful while visible, where row < 120 and col < 160.
   assign row = 7'(vc >> SCALE_SHIFT);
   assign col = 8'(hc >> SCALE_SHIFT);
   assign pix = colour_t'(rd_data);

   // Both stages step on tick edges: the RAM samples rd_addr on the clk in
   // between, so stage 2 sees the word for the address stage 1 issued.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         s1_vis    <= 1'b0;
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
         VGA_R     <= '0;
         VGA_G     <= '0;
         VGA_B     <= '0;
         VGA_HS    <= 1'b1;
         VGA_VS    <= 1'b1;
         VGA_BLANK <= 1'b0;
      end else if (pix_tick) begin
         rd_en  <= visible;
         s1_vis <= visible;
         s1_hs  <= hs_n;
         s1_vs  <= vs_n;
         if (visible) begin
            rd_addr <= ADDR_W'(fb_addr(row, col));
         end
         VGA_HS    <= s1_hs;
         VGA_VS    <= s1_vs;
         VGA_BLANK <= s1_vis;
         VGA_R     <= s1_vis ? {10{pix[2]}} : '0;
         VGA_G     <= s1_vis ? {10{pix[1]}} : '0;
         VGA_B     <= s1_vis ? {10{pix[0]}} : '0;
      end
   end

   assign VGA_SYNC = 1'b0;
   assign VGA_CLK  = pix_tick;

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader: full-size instance with a k mod 8 RAM and a
// short-frame instance with random RAM, both checked against a raster model.
module tb_vga_scanout_reader;

   localparam int BV_VIS = 8;
   localparam int BV_FP  = 1;
   localparam int BV_SYN = 2;
   localparam int BV_BP  = 1;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int t = 0;
   bit checking = 0;
   int fs_cnt_b = 0;

   logic [2:0] mem_a [0:19199];
   logic [2:0] mem_b [0:19199];

   logic        rd_en_a, rd_en_b;
   logic [14:0] rd_addr_a, rd_addr_b;
   logic [2:0]  rd_data_a = '0, rd_data_b = '0;
   logic [9:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic        hs_a, vs_a, blank_a, sync_a, vclk_a, fs_a;
   logic        hs_b, vs_b, blank_b, sync_b, vclk_b, fs_b;

   vga_scanout_reader dut_a (
      .clk (clk), .resetn (resetn), .rd_en (rd_en_a), .rd_addr (rd_addr_a),
      .rd_data (rd_data_a), .VGA_R (r_a), .VGA_G (g_a), .VGA_B (b_a),
      .VGA_HS (hs_a), .VGA_VS (vs_a), .VGA_BLANK (blank_a), .VGA_SYNC (sync_a),
      .VGA_CLK (vclk_a), .frame_start (fs_a)
   );

   vga_scanout_reader #(
      .V_VIS (BV_VIS), .V_FP (BV_FP), .V_SYNC (BV_SYN), .V_BP (BV_BP)
   ) dut_b (
      .clk (clk), .resetn (resetn), .rd_en (rd_en_b), .rd_addr (rd_addr_b),
      .rd_data (rd_data_b), .VGA_R (r_b), .VGA_G (g_b), .VGA_B (b_b),
      .VGA_HS (hs_b), .VGA_VS (vs_b), .VGA_BLANK (blank_b), .VGA_SYNC (sync_b),
      .VGA_CLK (vclk_b), .frame_start (fs_b)
   );

   // 1-clk-latency synchronous RAMs
   always @(posedge clk) begin
      if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
      if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
   end

   // t = number of clk edges since reset was last released
   always @(posedge clk) begin
      if (!resetn) t <= 0;
      else         t <= t + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Most recent framebuffer address reached at raster point (hc,vc).
   function automatic int last_addr(input int hc, input int vc, input int vv);
      if (vc < vv) return (vc / 4) * 160 + ((hc < 640) ? hc / 4 : 159);
      return ((vv - 1) / 4) * 160 + 159;
   endfunction

   // Expected {rd_en, rd_addr, R, G, B, HS, VS, BLANK, SYNC, CLK, frame_start}
   // t clk edges after reset release. The read request for raster point p
   // appears after edge 2p+2, the pins for p after edge 2p+4.
   function automatic logic [51:0] model(input int tt, input int vv, input int vf,
                                         input int vs, input int vb, input bit use_b);
      int ft, q, hc, vc, addr;
      logic en, hs, vsn, blank, fs, vclk;
      logic [14:0] ra;
      logic [2:0] c;
      logic [29:0] rgb;
      ft = 800 * (vv + vf + vs + vb);
      en = 0; ra = '0; rgb = '0; hs = 1; vsn = 1; blank = 0; fs = 0;
      vclk = (tt % 2) == 1;
      if (tt >= 2) begin
         q  = (tt / 2 - 1) % ft;
         hc = q % 800;
         vc = q / 800;
         en = (hc < 640) && (vc < vv);
         ra = 15'(last_addr(hc, vc, vv));
         fs = ((tt % 2) == 0) && (q == 0);
      end
      if (tt >= 4) begin
         q     = (tt / 2 - 2) % ft;
         hc    = q % 800;
         vc    = q / 800;
         blank = (hc < 640) && (vc < vv);
         hs    = !((hc >= 656) && (hc < 752));
         vsn   = !((vc >= vv + vf) && (vc < vv + vf + vs));
         if (blank) begin
            addr = (vc / 4) * 160 + hc / 4;
            c    = use_b ? mem_b[addr] : mem_a[addr];
            rgb  = {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
         end
      end
      return {en, ra, rgb, hs, vsn, blank, 1'b0, vclk, fs};
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         check("pins_a", {rd_en_a, rd_addr_a, r_a, g_a, b_a, hs_a, vs_a, blank_a, sync_a, vclk_a, fs_a},
               model(t, 480, 10, 2, 33, 1'b0));
         check("pins_b", {rd_en_b, rd_addr_b, r_b, g_b, b_b, hs_b, vs_b, blank_b, sync_b, vclk_b, fs_b},
               model(t, BV_VIS, BV_FP, BV_SYN, BV_BP, 1'b1));
         if (fs_b) fs_cnt_b++;
      end
   end

   task automatic wait_t(input int target);
      for (int i = 0; i < 100000 && t < target; i++) @(negedge clk);
   endtask

   // Waits for a level change on hs_a/vs_b; returns t or -1 on timeout.
   task automatic wait_edge(input bit sel_vs, input bit level, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((sel_vs ? vs_b : hs_a) == level) begin
            at = t;
            break;
         end
      end
   endtask

   initial begin
      int f1, r1, f2, fs0, fs1, skip;
      for (int k = 0; k < 19200; k++) begin
         mem_a[k] = 3'(k % 8);
         mem_b[k] = 3'($urandom);
      end
      resetn = 1'b0;
      @(posedge clk);
      checking = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pins", {hs_a, vs_a, blank_a, r_a, g_a, b_a, rd_en_a, rd_addr_a}, {3'b110, 30'd0, 16'd0});
      resetn = 1'b1;

      // Line timing on the full-size instance
      wait_edge(1'b0, 1'b0, 2000, f1);
      check("hs_fall_offset", f1 - 4, 1312);
      wait_edge(1'b0, 1'b1, 400, r1);
      check("hs_low_width", r1 - f1, 192);
      wait_edge(1'b0, 1'b0, 2000, f2);
      check("line_period", f2 - f1, 1600);

      // Pixel (4,4): address 161, colour 1 two clks later
      wait_t(6410);
      check("px44_addr", {rd_en_a, rd_addr_a}, {1'b1, 15'd161});
      wait_t(6412);
      check("px44_rgb", {r_a, g_a, b_a}, {10'h000, 10'h000, 10'h3ff});

      // End of visible line and start of blanking
      wait_t(7680);
      check("last_col_addr", rd_addr_a, 15'd319);
      wait_t(7684);
      check("blank_rd_data", rd_data_a, 3'd7);
      check("blank_pins", {blank_a, r_a, g_a, b_a}, 31'd0);

      // Short-frame instance: VS width, frame period, one frame_start per frame
      wait_edge(1'b1, 1'b0, 30000, f1);
      fs0 = fs_cnt_b;
      wait_edge(1'b1, 1'b1, 5000, r1);
      check("vs_low_width", r1 - f1, 3200);
      wait_edge(1'b1, 1'b0, 30000, f2);
      fs1 = fs_cnt_b;
      check("frame_period", f2 - f1, 19200);
      check("frame_start_count", fs1 - fs0, 1);

      // Mid-line reset at hc=300 on a random line
      skip = $urandom_range(0, 3);
      repeat (skip * 1600) @(negedge clk);
      for (int i = 0; i < 1700 && ((t % 1600) != 600); i++) @(negedge clk);
      check("reset_point_hc", (t / 2) % 800, 300);
      resetn = 1'b0;
      @(negedge clk);
      check("midrst_pins", {blank_a, r_a, g_a, b_a, rd_en_a, rd_addr_a}, 47'd0);
      resetn = 1'b1;
      wait_t(2);
      check("restart_addr", {rd_en_a, rd_addr_a, fs_a}, {1'b1, 15'd0, 1'b1});
      wait_t(24000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
